// File: rtl/piezo_tune_seq.sv
// Alarm-melody sequencer feeding the piezo duration counter and tone generator.
// Define PIEZO_TUNE_REPEAT_EN to loop the melody until stop instead of finishing with done.
module piezo_tune_seq #(
  parameter int unsigned GAP_TICKS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        note_over,
  output logic [15:0] note_per,
  output logic [7:0]  note_dur,
  output logic        dur_clr,
  output logic        piezo_on,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [7:0] GAP_LAST  = 8'(GAP_TICKS);
  localparam logic [2:0] LAST_NOTE = 3'd5;

  state_t      state, state_nx;
  logic [2:0]  idx, idx_nx;
  logic [7:0]  gap_cnt, gap_nx;
  logic        load_note;
  logic [15:0] tbl_per;
  logic [7:0]  tbl_dur;

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    gap_nx    = gap_cnt;
    load_note = 1'b0;
    if (stop) begin
      state_nx = IDLE;
      idx_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          idx_nx = '0;
          if (start) begin
            state_nx  = LOAD;
            load_note = 1'b1;
          end
        end
        LOAD: begin
          // the counter only clears on a tick, so note_over is stale until then
          if (tick) state_nx = PLAY;
        end
        PLAY: begin
          if (note_over) begin
            state_nx = GAP;
            gap_nx   = '0;
          end
        end
        GAP: begin
          if (tick) begin
            gap_nx = gap_cnt + 8'd1;
            if (gap_nx == GAP_LAST) begin
              if (idx == LAST_NOTE) begin
`ifdef PIEZO_TUNE_REPEAT_EN
                idx_nx    = '0;
                state_nx  = LOAD;
                load_note = 1'b1;
`else
                state_nx  = DONE;
`endif
              end else begin
                idx_nx    = idx + 3'd1;
                state_nx  = LOAD;
                load_note = 1'b1;
              end
            end
          end
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // decoded from the index being entered so the note is valid together with LOAD
  always_comb begin
    tbl_per = '0;
    tbl_dur = '0;
    case (idx_nx)
      3'd0: begin tbl_per = 16'd31888; tbl_dur = 8'd23; end
      3'd1: begin tbl_per = 16'd23889; tbl_dur = 8'd23; end
      3'd2: begin tbl_per = 16'd18961; tbl_dur = 8'd23; end
      3'd3: begin tbl_per = 16'd15944; tbl_dur = 8'd35; end
      3'd4: begin tbl_per = 16'd18961; tbl_dur = 8'd12; end
      3'd5: begin tbl_per = 16'd15944; tbl_dur = 8'd70; end
      default: begin tbl_per = '0; tbl_dur = '0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      gap_cnt  <= '0;
      note_per <= '0;
      note_dur <= '0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      gap_cnt <= gap_nx;
      if (load_note) begin
        note_per <= tbl_per;
        note_dur <= tbl_dur;
      end
    end
  end

  assign dur_clr  = (state == LOAD);
  assign piezo_on = (state == PLAY);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_piezo_tune_seq.sv
// Scoreboard bench for piezo_tune_seq with a tick source and duration-counter model.
module tb_piezo_tune_seq;

  logic        clk = 1'b0;
  logic        rst_n, tick, start, stop, note_over;
  logic [15:0] note_per;
  logic [7:0]  note_dur;
  logic        dur_clr, piezo_on, busy, done;

  localparam int GAP = 5;
  localparam int TP  = 10;

  always #5 clk = ~clk;

  piezo_tune_seq #(.GAP_TICKS(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
    .note_over(note_over), .note_per(note_per), .note_dur(note_dur),
    .dur_clr(dur_clr), .piezo_on(piezo_on), .busy(busy), .done(done)
  );

  int per_tab [6] = '{31888, 23889, 18961, 15944, 18961, 15944};
  int dur_tab [6] = '{23, 23, 23, 35, 12, 70};

  int total = 0;
  int bad   = 0;

  typedef struct { int per; int dur; } load_t;
  load_t q_load[$];
  int    q_play[$];
  int    q_gap[$];
  int    q_done[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_note(input int i, input bit with_play, input bit with_gap);
    load_t l;
    l.per = per_tab[i];
    l.dur = dur_tab[i];
    q_load.push_back(l);
    // note_over trails the count match by one tick, then the FSM needs one cycle
    if (with_play) q_play.push_back((dur_tab[i] + 1) * TP + 1);
    if (with_gap)  q_gap.push_back(GAP * TP - 1);
  endtask

  // tick source: first pulse on the first negedge after enabling
  logic tick_en;
  int   tick_cnt;
  initial begin
    tick = 1'b0;
    tick_cnt = 0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        tick = (tick_cnt == 0);
        tick_cnt = (tick_cnt == TP - 1) ? 0 : tick_cnt + 1;
      end else begin
        tick = 1'b0;
        tick_cnt = 0;
      end
    end
  end

  // duration counter: clears on tick while dur_clr, note_over registered on tick
  logic [7:0] dcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt      <= '0;
      note_over <= 1'b0;
    end else if (tick) begin
      if (dur_clr) begin
        dcnt      <= '0;
        note_over <= 1'b0;
      end else begin
        note_over <= (dcnt == note_dur);
        if (dcnt != note_dur) dcnt <= dcnt + 8'd1;
      end
    end
  end

  // monitor
  int  play_cnt, gap_cnt, done_seen;
  bit  prev_clr, prev_done;
  initial begin
    done_seen = 0;
    play_cnt = 0;
    gap_cnt = 0;
    prev_clr = 1'b0;
    prev_done = 1'b0;
  end

  always @(negedge clk) begin
    load_t e;
    int    w;
    if (!rst_n) begin
      play_cnt  = 0;
      gap_cnt   = 0;
      prev_clr  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (dur_clr && !prev_clr) begin
        if (q_load.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_load: got note_per %0d expected no load", note_per);
        end else begin
          e = q_load.pop_front();
          check("load_per", 32'(note_per), e.per);
          check("load_dur", 32'(note_dur), e.dur);
        end
      end
      if (piezo_on) play_cnt++;
      else if (play_cnt != 0) begin
        if (busy) begin
          if (q_play.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_play: got width %0d expected none", play_cnt);
          end else begin
            w = q_play.pop_front();
            check("play_width", play_cnt, w);
          end
        end
        play_cnt = 0;
      end
      if (busy && !piezo_on && !dur_clr && !done) gap_cnt++;
      else if (gap_cnt != 0) begin
        if (busy) begin
          if (q_gap.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_gap: got width %0d expected none", gap_cnt);
          end else begin
            w = q_gap.pop_front();
            check("gap_width", gap_cnt, w);
          end
        end
        gap_cnt = 0;
      end
      if (done) begin
        done_seen++;
        if (q_done.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done pulse %0d expected none", done_seen);
        end else begin
          w = q_done.pop_front();
          check("done_count", done_seen, w);
        end
      end
      if (prev_done) begin
        check("done_width", 32'(done), 0);
        check("busy_after_done", 32'(busy), 0);
      end
      prev_clr  = dur_clr;
      prev_done = done;
    end
  end

  task automatic wait_for(input int sel, input int limit, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0: hit = piezo_on && note_per == 16'd23889;
        1: hit = done;
        2: hit = busy && !piezo_on && !dur_clr && !done && note_per == 16'd15944 && note_dur == 8'd35;
        3: hit = piezo_on && note_per == 16'd18961 && note_dur == 8'd23;
        default: hit = (q_load.size() == 0);
      endcase
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL timeout_%s: got no event expected one within %0d cycles", name, limit);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_note_per"}, 32'(note_per), 0);
    check({tag, "_note_dur"}, 32'(note_dur), 0);
    check({tag, "_dur_clr"},  32'(dur_clr),  0);
    check({tag, "_piezo_on"}, 32'(piezo_on), 0);
    check({tag, "_busy"},     32'(busy),     0);
    check({tag, "_done"},     32'(done),     0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int loops;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; tick_en = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // full melody, tick withheld for 40 cycles in the first LOAD
`ifdef PIEZO_TUNE_REPEAT_EN
    loops = 3;
`else
    loops = 1;
`endif
    for (int l = 0; l < loops; l++)
      for (int i = 0; i < 6; i++) push_note(i, 1'b1, 1'b1);
`ifdef PIEZO_TUNE_REPEAT_EN
    push_note(0, 1'b0, 1'b0);
`else
    q_done.push_back(1);
`endif
    pulse_start();
    check("start_busy",    32'(busy),     1);
    check("start_dur_clr", 32'(dur_clr),  1);
    check("start_per",     32'(note_per), 31888);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("load_hold", 32'({dur_clr, piezo_on}), 32'b10);
    end
    @(posedge clk); #1 tick_en = 1'b1;
    @(posedge clk); #1 check("play_after_tick", 32'(piezo_on), 1);

    wait_for(0, 2000, "note1_play");
    pulse_start();
`ifdef PIEZO_TUNE_REPEAT_EN
    wait_for(5, 9000, "wrap_load");
    @(negedge clk);
    check("wrap_per", 32'(note_per), 31888);
    check("wrap_dur_clr", 32'(dur_clr), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("loop_stop_busy", 32'(busy), 0);
`else
    wait_for(1, 4000, "done");
    @(negedge clk);
    check("end_busy", 32'(busy), 0);
`endif
    @(negedge clk);
    check("drain_main", 32'(q_load.size() + q_play.size() + q_gap.size() + q_done.size()), 0);

    // stop during the gap after note 3, then replay from note 0
    for (int i = 0; i < 4; i++) push_note(i, 1'b1, i < 3);
    pulse_start();
    wait_for(2, 3000, "gap3");
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy",     32'(busy),     0);
    check("stop_piezo_on", 32'(piezo_on), 0);
    check("stop_dur_clr",  32'(dur_clr),  0);
    check("stop_done",     32'(done),     0);
    repeat (20) @(negedge clk);
    check("drain_stop", 32'(q_load.size() + q_play.size() + q_gap.size()), 0);
    push_note(0, 1'b0, 1'b0);
    pulse_start();
    check("restart_per", 32'(note_per), 31888);
    @(negedge clk);
    check("drain_restart", 32'(q_load.size()), 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("restart_stop_busy", 32'(busy), 0);

    // asynchronous reset in the middle of note 2
    for (int i = 0; i < 3; i++) push_note(i, i < 2, i < 2);
    pulse_start();
    wait_for(3, 2000, "note2_play");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_idx",  32'(dut.idx), 0);
    check("post_rst_gap",  32'(dut.gap_cnt), 0);
    @(negedge clk);
    check("drain_rst", 32'(q_load.size() + q_play.size() + q_gap.size() + q_done.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
